// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer.
// Holds the opcode map, the ALU increment code, the sequencer state
// encoding, the IR field positions and a helper that sorts an opcode
// into the action class the sequencer branches on.
package cpu_ctrl_pkg;

    // IR field positions for the default 5-bit opcode / 4-bit register fields.
    localparam int IR_MSB    = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    // Opcode map.
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SHR  = 5'h04;
    localparam logic [4:0] OP_SHRA = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_ROR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_NEG  = 5'h09;
    localparam logic [4:0] OP_NOT  = 5'h0A;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_MFHI = 5'h10;
    localparam logic [4:0] OP_MFLO = 5'h11;
    localparam logic [4:0] OP_NOP  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    // ALU code for B+1, used to advance the PC during fetch.
    localparam logic [3:0] ALUOP_INC = 4'hC;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_F3   = 4'd4,
        ST_E0   = 4'd5,
        ST_E1   = 4'd6,
        ST_E2   = 4'd7,
        ST_E3   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU     = 3'd0,
        CL_MUL     = 3'd1,
        CL_MFHI    = 3'd2,
        CL_MFLO    = 3'd3,
        CL_NOP     = 3'd4,
        CL_HALT    = 3'd5,
        CL_ILLEGAL = 3'd6
    } op_class_t;

    function automatic op_class_t decode_op(input logic [4:0] op);
        op_class_t cls;
        if (op <= OP_NOT) begin
            cls = CL_ALU;
        end else begin
            case (op)
                OP_MUL:  cls = CL_MUL;
                OP_MFHI: cls = CL_MFHI;
                OP_MFLO: cls = CL_MFLO;
                OP_NOP:  cls = CL_NOP;
                OP_HALT: cls = CL_HALT;
                default: cls = CL_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot register select decoder with enable.
// Ports:
//   sel    - binary register index
//   en     - when low the output is all zeros
//   onehot - one bit per register, at most one bit set
module reg_select_decoder #(
    parameter int SW = 4
) (
    input  logic [SW-1:0]      sel,
    input  logic               en,
    output logic [2**SW-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit that walks the register/bus datapath through
// fetch (F0..F3) and execute (E0..E3) for the instruction held in IR.
// Ports:
//   clock, clear           - rising-edge clock, synchronous active-high reset
//   run                    - start/continue, looked at in IDLE and at boundaries
//   mem_ready              - memory read data valid (F2 handshake)
//   ir                     - IR contents fed back from the datapath
//   Rin / Rout             - one-hot register load / bus drive
//   PCin..Zhighout         - datapath load and bus-drive strobes
//   ALUop, ALU_MUL         - ALU function, multiplier result select
//   MARin, Read            - memory address load and read request
//   instr_done, illegal    - per-instruction pulses
//   halted                 - high while in HALT
// All outputs depend only on the state register and ir, apart from MDRin,
// which also follows mem_ready so the MDR loads on the data-valid cycle.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int RFW = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [2**RFW-1:0]   Rin,
    output logic [2**RFW-1:0]   Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                IRin,
    output logic                Yin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                HIin,
    output logic                HIout,
    output logic                LOin,
    output logic                LOout,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic [3:0]          ALUop,
    output logic                ALU_MUL,
    output logic                MARin,
    output logic                Read,
    output logic                instr_done,
    output logic                illegal,
    output logic                halted
);

    localparam int OP_LSB = IR_MSB - OPW + 1;
    localparam int RA_LSB = OP_LSB - RFW;
    localparam int RB_LSB = RA_LSB - RFW;
    localparam int RC_LSB = RB_LSB - RFW;

    state_t           state;
    state_t           state_nxt;
    op_class_t        cls;
    logic [OPW-1:0]   op;
    logic [RFW-1:0]   ra;
    logic [RFW-1:0]   rb;
    logic [RFW-1:0]   rc;
    logic [RFW-1:0]   rout_sel;
    logic             rin_en;
    logic             rout_en;
    logic             unused_ir;

    assign op        = ir[IR_MSB -: OPW];
    assign ra        = ir[RA_LSB +: RFW];
    assign rb        = ir[RB_LSB +: RFW];
    assign rc        = ir[RC_LSB +: RFW];
    assign unused_ir = ^ir[RC_LSB-1:0];
    assign cls       = decode_op(5'(op));

    // E0 puts the first operand (rb) on the bus, E1 the second (rc).
    assign rout_sel  = (state == ST_E1) ? rc : rb;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        PCin       = 1'b0;
        PCout      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        HIin       = 1'b0;
        HIout      = 1'b0;
        LOin       = 1'b0;
        LOout      = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        ALUop      = 4'h0;
        ALU_MUL    = 1'b0;
        MARin      = 1'b0;
        Read       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_F0;
            end
            ST_F0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                ALUop     = ALUOP_INC;
                Zlowin    = 1'b1;
                state_nxt = ST_F1;
            end
            ST_F1: begin
                Zlowout   = 1'b1;
                PCin      = 1'b1;
                state_nxt = ST_F2;
            end
            ST_F2: begin
                Read = 1'b1;
                if (mem_ready) begin
                    MDRin     = 1'b1;
                    state_nxt = ST_F3;
                end
            end
            ST_F3: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = ST_E0;
            end
            ST_E0: begin
                case (cls)
                    CL_ALU, CL_MUL: begin
                        rout_en   = 1'b1;
                        Yin       = 1'b1;
                        state_nxt = ST_E1;
                    end
                    CL_MFHI: begin
                        HIout      = 1'b1;
                        rin_en     = 1'b1;
                        instr_done = 1'b1;
                    end
                    CL_MFLO: begin
                        LOout      = 1'b1;
                        rin_en     = 1'b1;
                        instr_done = 1'b1;
                    end
                    CL_HALT: begin
                        state_nxt = ST_HALT;
                    end
                    CL_ILLEGAL: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: begin
                        instr_done = 1'b1;
                    end
                endcase
            end
            ST_E1: begin
                rout_en   = 1'b1;
                ALUop     = op[3:0];
                Zlowin    = 1'b1;
                if (cls == CL_MUL) begin
                    ALU_MUL = 1'b1;
                    Zhighin = 1'b1;
                end
                state_nxt = ST_E2;
            end
            ST_E2: begin
                Zlowout = 1'b1;
                if (cls == CL_MUL) begin
                    LOin      = 1'b1;
                    state_nxt = ST_E3;
                end else begin
                    rin_en     = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_E3: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Instruction boundary: the only place run is looked at after start.
        if (instr_done) begin
            state_nxt = run ? ST_F0 : ST_IDLE;
        end
    end

    reg_select_decoder #(.SW(RFW)) u_rin_dec (
        .sel    (ra),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select_decoder #(.SW(RFW)) u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. The driver pushes the expected control
// word for every cycle of each instruction into exp_q before driving it;
// a monitor on the falling edge pops one word per cycle and compares the
// full set of DUT outputs against it.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic PCin, PCout, IRin, Yin, MDRin, MDRout, HIin, HIout, LOin, LOout;
    logic Zlowin, Zhighin, Zlowout, Zhighout;
    logic [3:0]  ALUop;
    logic ALU_MUL, MARin, Read, instr_done, illegal, halted;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        pc_in;
        logic        pc_out;
        logic        ir_in;
        logic        y_in;
        logic        mdr_in;
        logic        mdr_out;
        logic        hi_in;
        logic        hi_out;
        logic        lo_in;
        logic        lo_out;
        logic        zlow_in;
        logic        zhigh_in;
        logic        zlow_out;
        logic        zhigh_out;
        logic [3:0]  alu_op;
        logic        alu_mul;
        logic        mar_in;
        logic        read;
        logic        instr_done;
        logic        illegal;
        logic        halted;
    } ctrl_t;

    localparam int W = $bits(ctrl_t);

    logic [W-1:0] exp_q[$];
    logic [W-1:0] trace_q[$];
    int  vectors;
    int  miscompares;
    int  cyc;
    bit  mon_en;

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .Rin        (Rin),
        .Rout       (Rout),
        .PCin       (PCin),
        .PCout      (PCout),
        .IRin       (IRin),
        .Yin        (Yin),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .HIin       (HIin),
        .HIout      (HIout),
        .LOin       (LOin),
        .LOout      (LOout),
        .Zlowin     (Zlowin),
        .Zhighin    (Zhighin),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .ALUop      (ALUop),
        .ALU_MUL    (ALU_MUL),
        .MARin      (MARin),
        .Read       (Read),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Builds the cycle-by-cycle control words of one instruction from the
    // opcode table, with 'waits' memory wait cycles in the read.
    task automatic build_trace(input logic [31:0] instr, input int waits);
        ctrl_t      w;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit         is_alu, is_mul;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        is_alu = (op <= 5'h0A);
        is_mul = (op == 5'h0F);
        trace_q.delete();

        w = '0; w.pc_out = 1; w.mar_in = 1; w.alu_op = 4'hC; w.zlow_in = 1;
        trace_q.push_back(w);
        w = '0; w.zlow_out = 1; w.pc_in = 1;
        trace_q.push_back(w);
        for (int i = 0; i < waits; i++) begin
            w = '0; w.read = 1;
            trace_q.push_back(w);
        end
        w = '0; w.read = 1; w.mdr_in = 1;
        trace_q.push_back(w);
        w = '0; w.mdr_out = 1; w.ir_in = 1;
        trace_q.push_back(w);

        w = '0;
        if (is_alu || is_mul) begin
            w.rout = 16'd1 << rb; w.y_in = 1;
        end else if (op == 5'h10) begin
            w.hi_out = 1; w.rin = 16'd1 << ra; w.instr_done = 1;
        end else if (op == 5'h11) begin
            w.lo_out = 1; w.rin = 16'd1 << ra; w.instr_done = 1;
        end else if (op == 5'h1B) begin
            w = '0;
        end else begin
            w.instr_done = 1;
            w.illegal = (op != 5'h1A);
        end
        trace_q.push_back(w);

        if (is_alu || is_mul) begin
            w = '0; w.rout = 16'd1 << rc; w.alu_op = op[3:0]; w.zlow_in = 1;
            if (is_mul) begin
                w.alu_mul = 1; w.zhigh_in = 1;
            end
            trace_q.push_back(w);
            w = '0; w.zlow_out = 1;
            if (is_mul) begin
                w.lo_in = 1;
            end else begin
                w.rin = 16'd1 << ra; w.instr_done = 1;
            end
            trace_q.push_back(w);
            if (is_mul) begin
                w = '0; w.zhigh_out = 1; w.hi_in = 1; w.instr_done = 1;
                trace_q.push_back(w);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Each task is entered 1 time unit after a rising edge and drives one
    // cycle per loop iteration. run is held high in the cycle before an
    // instruction so it starts from IDLE or a boundary.
    task automatic do_idle(input int n, input bit last_run);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back('0);
            run = (j == n - 1) ? last_run : 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            ir = $urandom();
            clear = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic do_instr(input logic [31:0] instr, input int waits,
                            input bit run_next, input int abort_at);
        int n;
        build_trace(instr, waits);
        n = trace_q.size();
        if (abort_at >= 0) n = abort_at + 1;
        for (int i = 0; i < n; i++) exp_q.push_back(trace_q[i]);
        for (int i = 0; i < n; i++) begin
            if (i < 2) mem_ready = 1'($urandom_range(0, 1));
            else if (i < 2 + waits) mem_ready = 1'b0;
            else if (i == 2 + waits) mem_ready = 1'b1;
            else mem_ready = 1'($urandom_range(0, 1));
            ir = (i >= 4 + waits) ? instr : $urandom();
            run = (i == n - 1) ? run_next : 1'($urandom_range(0, 1));
            clear = (i == abort_at);
            @(posedge clock); #1;
        end
        clear = 1'b0;
    endtask

    // Sit in HALT for k cycles with run toggling, clear in the last one.
    task automatic do_halt_cycles(input int k);
        ctrl_t w;
        for (int j = 0; j < k; j++) begin
            w = '0; w.halted = 1;
            exp_q.push_back(w);
            run = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            clear = (j == k - 1);
            @(posedge clock); #1;
        end
        clear = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    ctrl_t        act;
    logic [W-1:0] act_w;
    logic [W-1:0] exp_w;

    always @(negedge clock) begin
        if (mon_en) begin
            act.rin = Rin;         act.rout = Rout;
            act.pc_in = PCin;      act.pc_out = PCout;
            act.ir_in = IRin;      act.y_in = Yin;
            act.mdr_in = MDRin;    act.mdr_out = MDRout;
            act.hi_in = HIin;      act.hi_out = HIout;
            act.lo_in = LOin;      act.lo_out = LOout;
            act.zlow_in = Zlowin;  act.zhigh_in = Zhighin;
            act.zlow_out = Zlowout; act.zhigh_out = Zhighout;
            act.alu_op = ALUop;    act.alu_mul = ALU_MUL;
            act.mar_in = MARin;    act.read = Read;
            act.instr_done = instr_done;
            act.illegal = illegal; act.halted = halted;
            act_w = act;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL ctrl_word cycle %0d: got %h, no expected word queued", cyc, act_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (act_w !== exp_w) begin
                    miscompares++;
                    $display("FAIL ctrl_word cycle %0d: got %h expected %h", cyc, act_w, exp_w);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] instr;
    int          waits;
    bit          rn;
    int          pick;

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        mon_en = 0;
        clear = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        ir = 32'h0;

        // Two cycles of clear with run low: outputs all zero.
        @(posedge clock); #1;
        exp_q.push_back('0);
        mon_en = 1;
        @(posedge clock); #1;
        clear = 1'b0;
        do_idle(2, 1'b1);

        // add R3,R1,R2 ; mul R0,R5,R6 ; aliasing add R7,R7,R7
        do_instr(32'h01890000, 0, 1'b1, -1);
        do_instr(32'h782B0000, 0, 1'b1, -1);
        do_instr(32'h03BB8000, 0, 1'b1, -1);
        // Three memory wait states, then drop run at the boundary.
        do_instr(32'h01890000, 3, 1'b0, -1);
        do_idle(3, 1'b1);
        // Undefined opcode 0x13, fetch resumes; then mfhi / mflo / nop.
        do_instr(32'h98000000, 0, 1'b1, -1);
        do_instr(32'h81000000, 1, 1'b1, -1);
        do_instr(32'h8A800000, 0, 1'b1, -1);
        do_instr(32'hD0000000, 2, 1'b1, -1);

        for (int k = 0; k < 40; k++) begin
            instr = $urandom();
            pick = $urandom_range(0, 29);
            if (pick <= 10) instr[31:27] = 5'(pick);
            else if (pick == 11) instr[31:27] = 5'h0F;
            else if (pick == 12) instr[31:27] = 5'h10;
            else if (pick == 13) instr[31:27] = 5'h11;
            else if (pick == 14) instr[31:27] = 5'h1A;
            if (instr[31:27] == 5'h1B) instr[31:27] = 5'h1A;
            waits = $urandom_range(0, 3);
            rn = ($urandom_range(0, 3) != 0);
            do_instr(instr, waits, rn, -1);
            if (!rn) do_idle($urandom_range(1, 3), 1'b1);
        end

        // clear during an F2 wait cycle.
        do_instr(32'h01890000, 3, 1'b1, 4);
        do_idle(2, 1'b1);

        // halt, sit in HALT with run toggling, then clear.
        do_instr(32'hD8000000, 1, 1'b1, -1);
        do_halt_cycles(6);
        do_idle(2, 1'b1);
        do_instr(32'hD0000000, 0, 1'b0, -1);
        do_idle(3, 1'b0);

        mon_en = 0;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
